// File: rtl/mem_wb_stage.sv
// Writeback stage with MEM/WB pipeline register, multi-cycle load stall and store-data forwarding.
// Optional load timeout (sticky mem_err) is compiled in with `define MEM_WB_TIMEOUT_EN.
module mem_wb_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_valid,
    input  logic        m_RegWrite,
    input  logic        m_MemRead,
    input  logic        m_MemWrite,
    input  logic        m_JAL,
    input  logic        m_LUI,
    input  logic [31:0] m_alu_out,
    input  logic [31:0] m_imm,
    input  logic [31:0] m_pc_inc,
    input  logic [4:0]  m_rd,
    input  logic [4:0]  m_rs2,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    input  logic        flush,
    output logic        stall_mem,
    output logic        wb_RegWrite,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_forward,
    output logic        mem_err
);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_READ = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic        commit;
    logic        timeout_hit;
    logic [31:0] result;

`ifdef MEM_WB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wait_cnt;

    assign timeout_hit = (state == WAIT_READ) && !mem_rvalid
                         && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Held at zero while idle, so it always starts from zero on entry to WAIT_READ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            if (state == WAIT_READ && !flush)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (timeout_hit && !flush)
                mem_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign mem_err     = 1'b0;
`endif

    always_comb begin
        if (m_JAL)
            result = m_pc_inc;
        else if (m_LUI)
            result = m_imm;
        else if (m_MemRead)
            result = mem_rdata;
        else
            result = m_alu_out;
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        stall_mem = 1'b0;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (m_valid) begin
                        if (!m_MemRead || mem_rvalid) begin
                            commit = 1'b1;
                        end else begin
                            state_nxt = WAIT_READ;
                            stall_mem = 1'b1;
                        end
                    end
                end
                WAIT_READ: begin
                    if (mem_rvalid) begin
                        commit    = 1'b1;
                        state_nxt = IDLE;
                    end else if (timeout_hit) begin
                        state_nxt = IDLE;
                    end else begin
                        stall_mem = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        // The state register is already IDLE during reset, but the inputs may still request a stall.
        if (rst)
            stall_mem = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wb_RegWrite <= 1'b0;
            wb_rd       <= 5'd0;
            wb_data     <= 32'd0;
        end else begin
            state <= state_nxt;
            if (commit) begin
                wb_RegWrite <= m_RegWrite && (m_rd != 5'd0);
                wb_rd       <= m_rd;
                wb_data     <= result;
            end else begin
                wb_RegWrite <= 1'b0;
            end
        end
    end

    assign wb_forward = wb_RegWrite && m_valid && m_MemWrite
                        && (m_rs2 != 5'd0) && (wb_rd == m_rs2);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized traffic
// compared against a transaction-level model of the writeback rules.
module tb_mem_wb_stage;

    localparam int TO = 4;
`ifdef MEM_WB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m_valid, m_RegWrite, m_MemRead, m_MemWrite, m_JAL, m_LUI;
    logic [31:0] m_alu_out, m_imm, m_pc_inc, mem_rdata;
    logic [4:0]  m_rd, m_rs2;
    logic        mem_rvalid, flush;
    logic        stall_mem, wb_RegWrite, wb_forward, mem_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    mem_wb_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_RegWrite(m_RegWrite), .m_MemRead(m_MemRead),
        .m_MemWrite(m_MemWrite), .m_JAL(m_JAL), .m_LUI(m_LUI),
        .m_alu_out(m_alu_out), .m_imm(m_imm), .m_pc_inc(m_pc_inc),
        .m_rd(m_rd), .m_rs2(m_rs2), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .flush(flush), .stall_mem(stall_mem), .wb_RegWrite(wb_RegWrite),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_forward(wb_forward), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural writeback port plus "a load is outstanding" bookkeeping.
    logic        e_we = 1'b0;
    logic [4:0]  e_rd = 5'd0;
    logic [31:0] e_data = 32'd0;
    logic        e_err = 1'b0;
    bit          pend = 1'b0;
    int          waited = 0;
    int          stall_seen = 0;
    logic        obs_stall, obs_fwd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_result();
        if (m_JAL)     return m_pc_inc;
        if (m_LUI)     return m_imm;
        if (m_MemRead) return mem_rdata;
        return m_alu_out;
    endfunction

    task automatic idle_inputs();
        m_valid = 0; m_RegWrite = 0; m_MemRead = 0; m_MemWrite = 0; m_JAL = 0; m_LUI = 0;
        m_alu_out = 0; m_imm = 0; m_pc_inc = 0; m_rd = 0; m_rs2 = 0;
        mem_rdata = 0; mem_rvalid = 0; flush = 0;
    endtask

    task automatic rand_instr();
        m_valid    = ($urandom % 8) != 0;
        m_RegWrite = ($urandom % 4) != 0;
        m_MemRead  = ($urandom % 3) == 0;
        m_MemWrite = ($urandom % 4) == 0;
        m_JAL      = ($urandom % 8) == 0;
        m_LUI      = ($urandom % 8) == 0;
        m_alu_out  = $urandom;
        m_imm      = $urandom;
        m_pc_inc   = $urandom;
        m_rd       = 5'($urandom % 4);
        m_rs2      = 5'($urandom % 4);
    endtask

    // Inputs are already driven (just after a rising edge). Checks combinational outputs at the
    // falling edge, advances the model, then checks the registered outputs after the next edge.
    task automatic step();
        logic commit, tmo, e_stall, e_fwd;
        @(negedge clk);
        commit = 0; tmo = 0; e_stall = 0;
        e_fwd = e_we && m_valid && m_MemWrite && (m_rs2 != 0) && (e_rd == m_rs2);
        if (flush) begin
            pend = 0;
        end else if (pend) begin
            if (mem_rvalid) begin
                commit = 1; pend = 0;
            end else if (TO_EN && waited == TO - 1) begin
                tmo = 1; pend = 0;
            end else begin
                e_stall = 1; waited++;
            end
        end else if (m_valid) begin
            if (!m_MemRead || mem_rvalid) commit = 1;
            else begin
                pend = 1; waited = 0; e_stall = 1;
            end
        end
        obs_stall = stall_mem;
        obs_fwd   = wb_forward;
        if (stall_mem) stall_seen++;
        check("stall_mem", 32'(stall_mem), 32'(e_stall));
        check("wb_forward", 32'(wb_forward), 32'(e_fwd));
        if (commit) begin
            e_we   = m_RegWrite && (m_rd != 0);
            e_rd   = m_rd;
            e_data = model_result();
        end else begin
            e_we = 0;
        end
        if (tmo) e_err = 1;
        @(posedge clk);
        #1;
        check("wb_RegWrite", 32'(wb_RegWrite), 32'(e_we));
        check("wb_rd", 32'(wb_rd), 32'(e_rd));
        check("wb_data", wb_data, e_data);
        check("mem_err", 32'(mem_err), 32'(e_err));
    endtask

    // Asserts reset with whatever inputs are driven, checks the asynchronous clear, then releases.
    task automatic apply_reset(input string tag);
        rst = 1;
        #1;
        check({tag, "_we"}, 32'(wb_RegWrite), 32'd0);
        check({tag, "_rd"}, 32'(wb_rd), 32'd0);
        check({tag, "_data"}, wb_data, 32'd0);
        check({tag, "_err"}, 32'(mem_err), 32'd0);
        check({tag, "_stall"}, 32'(stall_mem), 32'd0);
        check({tag, "_fwd"}, 32'(wb_forward), 32'd0);
        e_we = 0; e_rd = 0; e_data = 0; e_err = 0; pend = 0; waited = 0;
        repeat (2) @(posedge clk);
        idle_inputs();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] fwd_rs2 [3];
        logic       fwd_exp [3];
        fwd_rs2 = '{5'd9, 5'd0, 5'd8};
        fwd_exp = '{1'b1, 1'b0, 1'b0};

        // Reset with a load pending on the inputs: stall must stay low.
        idle_inputs();
        m_valid = 1; m_MemRead = 1; m_RegWrite = 1; m_rd = 3; m_MemWrite = 1; m_rs2 = 0;
        #1;
        apply_reset("reset");

        // ALU writeback
        idle_inputs();
        m_valid = 1; m_RegWrite = 1; m_rd = 5; m_alu_out = 32'h1234_5678;
        step();
        check("alu_we", 32'(wb_RegWrite), 32'd1);
        check("alu_rd", 32'(wb_rd), 32'd5);
        check("alu_data", wb_data, 32'h1234_5678);

        // JAL over LUI, then LUI alone
        idle_inputs();
        m_valid = 1; m_RegWrite = 1; m_rd = 3; m_JAL = 1; m_LUI = 1;
        m_pc_inc = 32'h104; m_imm = 32'hABCD_E000; m_alu_out = 32'hDEAD_BEEF;
        step();
        check("jal_data", wb_data, 32'h104);
        m_JAL = 0;
        step();
        check("lui_data", wb_data, 32'hABCD_E000);

        // Three-cycle load
        idle_inputs();
        m_valid = 1; m_RegWrite = 1; m_MemRead = 1; m_rd = 7; m_alu_out = 32'h55;
        stall_seen = 0;
        repeat (3) begin
            step();
            check("load_wait_we", 32'(wb_RegWrite), 32'd0);
        end
        mem_rvalid = 1; mem_rdata = 32'hFFFF_FF80;
        step();
        check("load_stall_cycles", 32'(stall_seen), 32'd3);
        check("load_we", 32'(wb_RegWrite), 32'd1);
        check("load_rd", 32'(wb_rd), 32'd7);
        check("load_data", wb_data, 32'hFFFF_FF80);
        idle_inputs();
        step();
        check("load_no_dup", 32'(wb_RegWrite), 32'd0);

        // x0 is never written
        idle_inputs();
        m_valid = 1; m_RegWrite = 1; m_rd = 0; m_alu_out = 32'hCAFE_F00D;
        step();
        check("x0_we", 32'(wb_RegWrite), 32'd0);

        // Flush in the second WAIT_READ cycle beats a simultaneous rvalid
        idle_inputs();
        m_valid = 1; m_RegWrite = 1; m_MemRead = 1; m_rd = 6;
        step();
        step();
        flush = 1; mem_rvalid = 1; mem_rdata = 32'h1111_2222;
        step();
        check("flush_stall", 32'(obs_stall), 32'd0);
        check("flush_we", 32'(wb_RegWrite), 32'd0);
        idle_inputs();
        mem_rvalid = 1; mem_rdata = 32'h3333_4444;
        step();
        check("stray_rvalid_we", 32'(wb_RegWrite), 32'd0);

        // Forwarding to a following store
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            m_valid = 1; m_RegWrite = 1; m_rd = 9; m_alu_out = $urandom;
            step();
            idle_inputs();
            m_valid = 1; m_MemWrite = 1; m_rs2 = fwd_rs2[i];
            step();
            check("fwd_select", 32'(obs_fwd), 32'(fwd_exp[i]));
        end

        // Reset in the middle of a load wait
        idle_inputs();
        m_valid = 1; m_RegWrite = 1; m_rd = 12; m_alu_out = 32'h0BAD_F00D;
        step();
        idle_inputs();
        m_valid = 1; m_RegWrite = 1; m_MemRead = 1; m_rd = 4;
        step();
        apply_reset("midwait");
        mem_rvalid = 1; mem_rdata = 32'h7777_7777;
        step();
        check("midwait_discard_we", 32'(wb_RegWrite), 32'd0);

`ifdef MEM_WB_TIMEOUT_EN
        // Load that never returns
        idle_inputs();
        m_valid = 1; m_RegWrite = 1; m_MemRead = 1; m_rd = 10;
        stall_seen = 0;
        repeat (TO + 1) step();
        check("timeout_stall_cycles", 32'(stall_seen), 32'(TO));
        check("timeout_err", 32'(mem_err), 32'd1);
        check("timeout_no_commit", 32'(wb_RegWrite), 32'd0);
        idle_inputs();
        repeat (3) step();
        check("timeout_err_sticky", 32'(mem_err), 32'd1);
        apply_reset("err_clear");
`endif

        // Randomized traffic; upstream holds the instruction while a load is outstanding
        idle_inputs();
        for (int n = 0; n < 400; n++) begin
            if (!pend) rand_instr();
            mem_rvalid = ($urandom % 3) == 0;
            mem_rdata  = $urandom;
            flush      = ($urandom % 16) == 0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Writeback stage plus MEM/WB pipeline register. It sits directly downstream of the data-memory stage and accepts either its load data or the pass-through ALU, immediate or link result. It handles multi-cycle load latency by stalling the pipe, and drives the register-file write port. It also produces the writeback-to-store forwarding select (`wb_forward`/`wb_data`) consumed by the memory stage.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum cycles spent waiting for load data; used only when the timeout feature is compiled in.

Ports:
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `m_valid` in 1: the MEM stage holds a live instruction.
- `m_RegWrite` in 1: the instruction writes rd.
- `m_MemRead` in 1: load.
- `m_MemWrite` in 1: store.
- `m_JAL` in 1: result is `m_pc_inc`.
- `m_LUI` in 1: result is `m_imm`.
- `m_alu_out` in 32: ALU result.
- `m_imm` in 32: immediate.
- `m_pc_inc` in 32: PC+4.
- `m_rd` in 5: destination register.
- `m_rs2` in 5: store data source register.
- `mem_rdata` in 32: load data, already extended by the memory stage.
- `mem_rvalid` in 1: `mem_rdata` is valid this cycle.
- `flush` in 1: kill the MEM-stage instruction.
- `stall_mem` out 1: freeze the upstream stages.
- `wb_RegWrite` out 1: register-file write enable.
- `wb_rd` out 5: register-file write address.
- `wb_data` out 32: register-file write data, and forward data to the memory stage.
- `wb_forward` out 1: memory stage takes its store data from `wb_data`.
- `mem_err` out 1: sticky load-timeout flag.

## Operation
- State machine: IDLE, WAIT_READ.
- Result select, in priority order:
  - `m_JAL` → `m_pc_inc`
  - `m_LUI` → `m_imm`
  - `m_MemRead` → `mem_rdata`
  - otherwise → `m_alu_out`
- Commit means: on the clock edge, `wb_RegWrite <= m_RegWrite & (m_rd != 0)`, `wb_rd <= m_rd`, `wb_data <= selected result`.
- A bubble means `wb_RegWrite <= 0`. `wb_rd` and `wb_data` hold their values during a bubble.
- IDLE:
  - `m_valid=0` → bubble.
  - Non-load, or load with `mem_rvalid=1` → commit, stay in IDLE.
  - Load with `mem_rvalid=0` → bubble, go to WAIT_READ.
- WAIT_READ:
  - Upstream holds all `m_*` inputs stable.
  - `mem_rvalid=1` → commit the load, go to IDLE.
  - Otherwise → bubble, stay in WAIT_READ.
- `stall_mem` is combinational:
  - In IDLE: `m_valid & m_MemRead & ~mem_rvalid & ~flush`.
  - In WAIT_READ: `~mem_rvalid & ~flush`.
- Flush has top priority in either state: bubble, go to IDLE, `stall_mem=0` that cycle.
- x0 is never written. `wb_RegWrite` stays 0 when `m_rd=0`, even with `m_RegWrite=1`.
- Forwarding is combinational from registered state:
  - `wb_forward = wb_RegWrite & m_valid & m_MemWrite & (m_rs2 != 0) & (wb_rd == m_rs2)`.

## Timing
- Reset values: state IDLE; `wb_RegWrite=0`, `wb_rd=0`, `wb_data=0`, `mem_err=0`, timeout counter 0.
- `stall_mem` and `wb_forward` are 0 during reset.
- Non-load latency: inputs valid in cycle N → register-file write visible after edge N+1.
- Load latency: committed on the edge of the cycle in which `mem_rvalid=1`. `stall_mem` drops in that same cycle.
- A new instruction is accepted the cycle after a load commits. No back-to-back loss or duplication.
- Reset mid-wait: outputs clear immediately (async), and the pending load is discarded.
- `mem_rvalid` asserted in IDLE with no load pending is ignored.
- Flush and `mem_rvalid` in the same cycle: the flush wins and no commit occurs.

## Configuration
- `MEM_WB_TIMEOUT_EN` defined:
  - A counter runs in WAIT_READ. It resets to 0 on entry and increments each waiting cycle.
  - On the cycle the counter equals `TIMEOUT_CYCLES-1` with `mem_rvalid=0`: bubble, set `mem_err`, return to IDLE, drop `stall_mem`.
  - `mem_err` stays set until `rst`.
- `MEM_WB_TIMEOUT_EN` undefined:
  - No counter; WAIT_READ persists until `mem_rvalid`.
  - `mem_err` is tied to 0.

## Test plan
- ALU writeback: `m_valid=1`, `m_RegWrite=1`, `m_rd=5`, `m_alu_out=32'h1234_5678` → next cycle `wb_RegWrite=1`, `wb_rd=5`, `wb_data=32'h1234_5678`, `stall_mem=0` throughout.
- JAL/LUI priority: `m_JAL=1`, `m_LUI=1`, `m_pc_inc=32'h104`, `m_imm=32'hABCD_E000` → `wb_data=32'h104`. Repeat with `m_JAL=0` → `wb_data=32'hABCD_E000`.
- Multi-cycle load: load to `rd=7` with `mem_rvalid` low for 3 cycles, then `mem_rdata=32'hFFFF_FF80` → `stall_mem=1` for exactly 3 cycles, `wb_RegWrite=0` during the wait, then `wb_data=32'hFFFF_FF80`, `wb_rd=7` on one commit.
- x0 and flush: `m_rd=0` with `m_RegWrite=1` → `wb_RegWrite=0`. Separately, flush asserted in the 2nd WAIT_READ cycle → state IDLE, `stall_mem=0`, no commit even if `mem_rvalid` is asserted later.
- Forwarding: commit `rd=9`, then a store with `m_rs2=9`, `m_MemWrite=1` → `wb_forward=1`. Same case with `m_rs2=0` or `m_rs2=8` → `wb_forward=0`.
- Timeout (macro on, `TIMEOUT_CYCLES=4`): load with `mem_rvalid` held low → `stall_mem` high for 4 cycles, then `mem_err=1` stays set, no commit. `mem_err` clears only on `rst`.
